mc_datapath_regs: RTL and testbench

//  Architectural/non-architectural register stage of the multicycle RISC-V datapath, driven by the FSM control unit.

---
 rtl/mc_datapath_regs_pkg.sv | 39 +++
 rtl/mc_datapath_regs_imm_gen.sv | 22 ++
 rtl/mc_datapath_regs.sv | 86 ++++++++
 tb/tb_mc_datapath_regs.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_datapath_regs_pkg.sv
// Shared opcode constants and immediate-format decode for the multicycle datapath.
package mc_datapath_regs_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    FMT_NONE,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_J,
    FMT_U
  } imm_fmt_e;

  // Map an opcode to the immediate layout it carries; R-type and unknown carry none.
  function automatic imm_fmt_e imm_fmt(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_ITYPE, OP_JALR: imm_fmt = FMT_I;
      OP_STORE:                   imm_fmt = FMT_S;
      OP_BRANCH:                  imm_fmt = FMT_B;
      OP_JAL:                     imm_fmt = FMT_J;
      OP_LUI, OP_AUIPC:           imm_fmt = FMT_U;
      OP_RTYPE:                   imm_fmt = FMT_NONE;
      default:                    imm_fmt = FMT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mc_datapath_regs_imm_gen.sv
// Combinational immediate generator: sign-extended immediate for the instruction in IR.
module mc_datapath_regs_imm_gen
  import mc_datapath_regs_pkg::*;
(
  input  logic [31:0] ir,
  output logic [31:0] imm
);

  // Select the bit layout by opcode class.
  always_comb begin
    imm = 32'h0;
    case (imm_fmt(ir[6:0]))
      FMT_I:   imm = {{20{ir[31]}}, ir[31:20]};
      FMT_S:   imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      FMT_B:   imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      FMT_J:   imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      FMT_U:   imm = {ir[31:12], 12'h000};
      default: imm = 32'h0;
    endcase
  end

endmodule

// File: rtl/mc_datapath_regs.sv
// Register stage of the multicycle RISC-V datapath: PC, IR, MDR, ALUOut,
// memory address mux, IR field decode and immediate generation.
module mc_datapath_regs #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = mc_datapath_regs_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCWrite,
  input  logic        PCWriteCond,
  input  logic        PCSource,
  input  logic        IRWrite,
  input  logic        IorD,
  input  logic        Zero,
  input  logic [31:0] ALUResult,
  input  logic [31:0] MemData,
  output logic [31:0] PC,
  output logic [31:0] MemAddr,
  output logic [31:0] IR,
  output logic [31:0] MDR,
  output logic [31:0] ALUOut,
  output logic [6:0]  opcode,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [31:0] Imm,
  output logic        pc_misaligned
);

  import mc_datapath_regs_pkg::*;

  logic        pc_en;
  logic [31:0] pc_next;

  // PC load enable and source select; PCWrite dominates the Zero qualification.
  always_comb begin
    pc_en   = PCWrite | (PCWriteCond & Zero);
    pc_next = PCSource ? ALUOut : ALUResult;
  end

  // Program counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      PC <= RESET_PC;
    else if (pc_en) PC <= pc_next;
  end

  // Sticky flag: any PC load with a non-word-aligned target; the load itself still happens.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                               pc_misaligned <= 1'b0;
    else if (pc_en && (pc_next[1:0] != 2'b00)) pc_misaligned <= 1'b1;
  end

  // Instruction register; on a fetch edge it captures data read at the old PC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        IR <= NOP_INSTR;
    else if (IRWrite) IR <= MemData;
  end

  // Non-architectural pipeline-style registers, loaded every cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      MDR    <= 32'h0;
      ALUOut <= 32'h0;
    end else begin
      MDR    <= MemData;
      ALUOut <= ALUResult;
    end
  end

  assign MemAddr = IorD ? ALUOut : PC;

  assign opcode = IR[6:0];
  assign rd     = IR[11:7];
  assign funct3 = IR[14:12];
  assign rs1    = IR[19:15];
  assign rs2    = IR[24:20];
  assign funct7 = IR[31:25];

  mc_datapath_regs_imm_gen u_imm_gen (
    .ir  (IR),
    .imm (Imm)
  );

endmodule

// File: tb/tb_mc_datapath_regs.sv
// Self-checking bench for mc_datapath_regs: directed scenarios plus randomized
// strobes checked against a register-level behavioural model.
module tb_mc_datapath_regs;

  logic        clk;
  logic        reset;
  logic        PCWrite, PCWriteCond, PCSource, IRWrite, IorD, Zero;
  logic [31:0] ALUResult, MemData;
  logic [31:0] PC, MemAddr, IR, MDR, ALUOut, Imm;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic        pc_misaligned;

  int total = 0;
  int bad   = 0;

  // model state
  logic [31:0] m_pc, m_ir, m_mdr, m_aluout;
  logic        m_mis;

  mc_datapath_regs dut (
    .clk(clk), .reset(reset),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSource(PCSource),
    .IRWrite(IRWrite), .IorD(IorD), .Zero(Zero),
    .ALUResult(ALUResult), .MemData(MemData),
    .PC(PC), .MemAddr(MemAddr), .IR(IR), .MDR(MDR), .ALUOut(ALUOut),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .Imm(Imm),
    .pc_misaligned(pc_misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Immediate from the ISA's field placement, assembled arithmetically.
  function automatic logic [31:0] ref_imm(input logic [31:0] ir);
    logic [31:0] v;
    v = 32'h0;
    case (ir[6:0])
      7'b0000011, 7'b0010011, 7'b1100111:
        v = 32'($signed(ir) >>> 20);
      7'b0100011:
        v = (32'($signed(ir) >>> 20) & ~32'h1F) | 32'(ir[11:7]);
      7'b1100011:
        v = (ir[31] ? 32'hFFFF_F000 : 32'h0) + 32'(ir[7]) * 2048
            + 32'(ir[30:25]) * 32 + 32'(ir[11:8]) * 2;
      7'b1101111:
        v = (ir[31] ? 32'hFFF0_0000 : 32'h0) + 32'(ir[19:12]) * 4096
            + 32'(ir[20]) * 2048 + 32'(ir[30:21]) * 2;
      7'b0110111, 7'b0010111:
        v = ir & 32'hFFFF_F000;
      default: v = 32'h0;
    endcase
    return v;
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_ir = 32'h0000_0013; m_mdr = 32'h0; m_aluout = 32'h0; m_mis = 1'b0;
  endtask

  task automatic set_idle();
    PCWrite = 0; PCWriteCond = 0; PCSource = 0; IRWrite = 0; IorD = 0; Zero = 0;
  endtask

  // Advance the model with the currently applied inputs, then clock the DUT.
  task automatic tick();
    logic [31:0] tgt;
    tgt = PCSource ? m_aluout : ALUResult;
    if (PCWrite || (PCWriteCond && Zero)) begin
      m_pc = tgt;
      if (tgt % 4 != 0) m_mis = 1'b1;
    end
    if (IRWrite) m_ir = MemData;
    m_mdr    = MemData;
    m_aluout = ALUResult;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; set_idle(); ALUResult = 32'h0; MemData = 32'h0;
    #12 reset = 1'b0;
    model_reset();
    // move everything away from reset values
    PCWrite = 1; IRWrite = 1; ALUResult = 32'h0000_0042; MemData = 32'h1234_5678;
    tick();
    set_idle();
    // assert reset mid-cycle and look before the next edge
    #3 reset = 1'b1;
    #1;
    model_reset();
    total++; if (PC !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=%h", PC, 32'h0); end
    total++; if (IR !== 32'h0000_0013) begin bad++; $display("FAIL reset_ir got=%h exp=%h", IR, 32'h13); end
    total++; if (opcode !== 7'b0010011) begin bad++; $display("FAIL reset_opcode got=%b exp=%b", opcode, 7'b0010011); end
    total++; if (MDR !== 32'h0) begin bad++; $display("FAIL reset_mdr got=%h exp=0", MDR); end
    total++; if (ALUOut !== 32'h0) begin bad++; $display("FAIL reset_aluout got=%h exp=0", ALUOut); end
    total++; if (pc_misaligned !== 1'b0) begin bad++; $display("FAIL reset_mis got=%b exp=0", pc_misaligned); end
    #2 reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_fetch();
    set_idle();
    IRWrite = 1; PCWrite = 1; PCSource = 0; MemData = 32'h0002_A303; ALUResult = 32'h4;
    tick();
    set_idle();
    total++; if (IR !== 32'h0002_A303) begin bad++; $display("FAIL fetch_ir got=%h exp=%h", IR, 32'h0002A303); end
    total++; if (PC !== 32'h4) begin bad++; $display("FAIL fetch_pc got=%h exp=4", PC); end
    total++; if (opcode !== 7'b0000011) begin bad++; $display("FAIL fetch_opcode got=%b exp=0000011", opcode); end
    total++; if (rd !== 5'd6) begin bad++; $display("FAIL fetch_rd got=%0d exp=6", rd); end
    total++; if (rs1 !== 5'd5) begin bad++; $display("FAIL fetch_rs1 got=%0d exp=5", rs1); end
    total++; if (Imm !== 32'h0) begin bad++; $display("FAIL fetch_imm got=%h exp=0", Imm); end
  endtask

  task automatic test_store_iord();
    set_idle();
    IRWrite = 1; MemData = 32'hFE53_2E23; ALUResult = 32'h100;
    tick();
    set_idle();
    ALUResult = 32'h0;
    total++; if (opcode !== 7'b0100011) begin bad++; $display("FAIL store_opcode got=%b exp=0100011", opcode); end
    total++; if (rs1 !== 5'd6) begin bad++; $display("FAIL store_rs1 got=%0d exp=6", rs1); end
    total++; if (rs2 !== 5'd5) begin bad++; $display("FAIL store_rs2 got=%0d exp=5", rs2); end
    total++; if (Imm !== 32'hFFFF_FFFC) begin bad++; $display("FAIL store_imm got=%h exp=fffffffc", Imm); end
    IorD = 1; #1;
    total++; if (MemAddr !== 32'h100) begin bad++; $display("FAIL iord1_memaddr got=%h exp=100", MemAddr); end
    IorD = 0; #1;
    total++; if (MemAddr !== m_pc) begin bad++; $display("FAIL iord0_memaddr got=%h exp=%h", MemAddr, m_pc); end
  endtask

  task automatic test_branch();
    logic [31:0] held;
    set_idle();
    ALUResult = 32'h20;
    tick();
    held = m_pc;
    PCWriteCond = 1; PCSource = 1; Zero = 0; ALUResult = 32'h20;
    tick();
    total++; if (PC !== held) begin bad++; $display("FAIL branch_not_taken got=%h exp=%h", PC, held); end
    Zero = 1;
    tick();
    total++; if (PC !== 32'h20) begin bad++; $display("FAIL branch_taken got=%h exp=20", PC); end
    // both strobes high: loads even with Zero low
    PCWrite = 1; PCWriteCond = 1; Zero = 0; PCSource = 0; ALUResult = 32'h44;
    tick();
    total++; if (PC !== 32'h44) begin bad++; $display("FAIL both_strobes got=%h exp=44", PC); end
    set_idle();
  endtask

  task automatic test_misalign();
    set_idle();
    PCWrite = 1; ALUResult = 32'h6;
    tick();
    total++; if (PC !== 32'h6) begin bad++; $display("FAIL mis_pc got=%h exp=6", PC); end
    total++; if (pc_misaligned !== 1'b1) begin bad++; $display("FAIL mis_set got=%b exp=1", pc_misaligned); end
    ALUResult = 32'h8;
    tick();
    total++; if (PC !== 32'h8) begin bad++; $display("FAIL mis_pc8 got=%h exp=8", PC); end
    total++; if (pc_misaligned !== 1'b1) begin bad++; $display("FAIL mis_sticky got=%b exp=1", pc_misaligned); end
    set_idle();
    #2 reset = 1'b1; #1 model_reset();
    total++; if (pc_misaligned !== 1'b0) begin bad++; $display("FAIL mis_clear got=%b exp=0", pc_misaligned); end
    #2 reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_hold();
    logic [31:0] pc0, ir0, prev;
    set_idle();
    pc0 = m_pc; ir0 = m_ir;
    for (int i = 0; i < 5; i++) begin
      prev = (i % 2 == 0) ? 32'hA5A5_5A5A : 32'h5A5A_A5A5;
      MemData = prev;
      tick();
      total++; if (PC !== pc0 || IR !== ir0) begin bad++; $display("FAIL hold_pc_ir cyc=%0d got=%h/%h exp=%h/%h", i, PC, IR, pc0, ir0); end
      total++; if (MDR !== prev) begin bad++; $display("FAIL hold_mdr cyc=%0d got=%h exp=%h", i, MDR, prev); end
    end
  endtask

  task automatic test_random();
    logic [6:0]  ops [10];
    logic [31:0] r, w;
    logic [31:0] got [12];
    logic [31:0] exp [12];
    ops = '{7'b0000011, 7'b0100011, 7'b1100011, 7'b0110011, 7'b0010011,
            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1110011};
    for (int n = 0; n < 300; n++) begin
      PCWrite     = ($urandom % 4) == 0;
      PCWriteCond = ($urandom % 3) == 0;
      PCSource    = $urandom % 2;
      Zero        = $urandom % 2;
      IRWrite     = ($urandom % 3) == 0;
      r = $urandom;
      if ($urandom % 8 != 0) r[1:0] = 2'b00;
      ALUResult = r;
      w = $urandom;
      w[6:0] = ops[$urandom % 10];
      MemData = w;
      if ($urandom % 60 == 0) begin
        #2 reset = 1'b1; #1 model_reset(); #1 reset = 1'b0;
      end
      tick();
      IorD = $urandom % 2;
      #1;
      got[0] = PC;            exp[0] = m_pc;
      got[1] = IR;            exp[1] = m_ir;
      got[2] = MDR;           exp[2] = m_mdr;
      got[3] = ALUOut;        exp[3] = m_aluout;
      got[4] = MemAddr;       exp[4] = IorD ? m_aluout : m_pc;
      got[5] = Imm;           exp[5] = ref_imm(m_ir);
      got[6] = 32'(pc_misaligned); exp[6] = 32'(m_mis);
      got[7] = 32'(opcode);   exp[7] = m_ir & 32'h7F;
      got[8] = 32'(rd);       exp[8] = (m_ir >> 7) & 32'h1F;
      got[9] = 32'(rs1);      exp[9] = (m_ir >> 15) & 32'h1F;
      got[10] = 32'(rs2);     exp[10] = (m_ir >> 20) & 32'h1F;
      got[11] = {funct7, 22'h0, funct3}; exp[11] = ((m_ir >> 25) << 25) | ((m_ir >> 12) & 32'h7);
      for (int k = 0; k < 12; k++) begin
        total++;
        if (got[k] !== exp[k]) begin
          bad++;
          $display("FAIL random iter=%0d item=%0d got=%h exp=%h", n, k, got[k], exp[k]);
        end
      end
    end
    set_idle();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store_iord();
    test_branch();
    test_misalign();
    test_hold();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
